// File: rtl/mux3to1_fwd.sv
// mux3to1_fwd: 3-to-1 forwarding-path selector for the ALU operand.
//   sel 00 -> A (register file), 01 -> B (EX/MEM), 10 -> C (MEM/WB), 11 -> zero.
// Combinational output plus a one-cycle registered copy with a valid flag,
// and a sticky flag recording any captured use of the illegal select code.
// Optional build macro MUX3TO1_FWD_STATS_EN adds saturating per-source
// usage counters (cnt_a, cnt_b, cnt_c, CNT_W bits each).
module mux3to1_fwd #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [1:0]       sel,
  input  logic             en,
  input  logic             sel_err_clr,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_vld,
`ifdef MUX3TO1_FWD_STATS_EN
  output logic             sel_err,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_c
`else
  output logic             sel_err
`endif
);

  logic sel_ill;

  assign sel_ill = (sel == 2'b11);

  // Select the forwarded operand; illegal or unknown select codes fall to
  // the default arm so the output is forced to zero rather than X.
  always_comb begin
    out = '0;
    case (sel)
      2'b00:   out = A;
      2'b01:   out = B;
      2'b10:   out = C;
      default: out = '0;
    endcase
  end

  // Registered copy of the selected value; holds when en is low while the
  // valid flag drops so consumers know the copy is stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      out_vld <= 1'b0;
    end else begin
      out_vld <= en;
      if (en) out_q <= out;
    end
  end

  // Sticky illegal-select flag; a new set on the clearing edge wins so a
  // fresh error is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else if (en && sel_ill) begin
      sel_err <= 1'b1;
    end else if (sel_err_clr) begin
      sel_err <= 1'b0;
    end
  end

`ifdef MUX3TO1_FWD_STATS_EN
  // Saturating usage counters, one per legal source; illegal selects count nowhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a <= '0;
      cnt_b <= '0;
      cnt_c <= '0;
    end else if (en) begin
      if (sel == 2'b00 && cnt_a != '1) cnt_a <= cnt_a + 1'b1;
      if (sel == 2'b01 && cnt_b != '1) cnt_b <= cnt_b + 1'b1;
      if (sel == 2'b10 && cnt_c != '1) cnt_c <= cnt_c + 1'b1;
    end
  end
`else
  // Width of the usage counters only matters when statistics are built in.
  localparam int CntWUnused = CNT_W;
  logic cnt_w_unused;
  assign cnt_w_unused = (CntWUnused != 0);
`endif

endmodule

// File: tb/tb_mux3to1_fwd.sv
// Directed testbench for mux3to1_fwd with hand-computed expected values.
// Build with MUX3TO1_FWD_STATS_EN defined to also exercise the usage counters.
module tb_mux3to1_fwd;

  localparam int WIDTH = 64;
`ifdef MUX3TO1_FWD_STATS_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  localparam logic [63:0] VA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] VB = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [63:0] VC = 64'hCCCC_CCCC_CCCC_CCCC;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] A, B, C;
  logic [1:0]       sel;
  logic             en;
  logic             sel_err_clr;
  logic [WIDTH-1:0] out, out_q;
  logic             out_vld;
  logic             sel_err;
`ifdef MUX3TO1_FWD_STATS_EN
  logic [CNT_W-1:0] cnt_a, cnt_b, cnt_c;
`endif

  int n_chk = 0;
  int n_bad = 0;

  mux3to1_fwd #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .A           (A),
    .B           (B),
    .C           (C),
    .sel         (sel),
    .en          (en),
    .sel_err_clr (sel_err_clr),
    .out         (out),
    .out_q       (out_q),
    .out_vld     (out_vld),
`ifdef MUX3TO1_FWD_STATS_EN
    .sel_err     (sel_err),
    .cnt_a       (cnt_a),
    .cnt_b       (cnt_b),
    .cnt_c       (cnt_c)
`else
    .sel_err     (sel_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge, landing 1 unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; A = VA; B = VB; C = VC;
    sel = 2'b00; en = 1'b0; sel_err_clr = 1'b0;
    #2;
    chk("rst_out_q", out_q, 64'h0);
    chk("rst_out_vld", {63'h0, out_vld}, 64'h0);
    chk("rst_sel_err", {63'h0, sel_err}, 64'h0);
    chk("rst_out_follows", out, VA);
    tick();
    @(negedge clk);
    rst = 1'b0;

    // Combinational select with en low.
    sel = 2'b00; #10; chk("comb_a", out, VA);
    sel = 2'b01; #10; chk("comb_b", out, VB);
    sel = 2'b10; #10; chk("comb_c", out, VC);
    chk("vld_en0", {63'h0, out_vld}, 64'h0);
    chk("q_hold_en0", out_q, 64'h0);

    // A second data pattern to catch crossed wiring.
    A = 64'h0123_4567_89AB_CDEF; B = 64'hFEDC_BA98_7654_3210; C = 64'h5A5A_0F0F_F0F0_A5A5;
    sel = 2'b00; #1; chk("comb_a2", out, 64'h0123_4567_89AB_CDEF);
    sel = 2'b01; #1; chk("comb_b2", out, 64'hFEDC_BA98_7654_3210);
    sel = 2'b10; #1; chk("comb_c2", out, 64'h5A5A_0F0F_F0F0_A5A5);
    A = VA; B = VB; C = VC;

    // Illegal select: zero output, no flag while en is low.
    sel = 2'b11; #1; chk("comb_ill", out, 64'h0);
    tick();
    chk("ill_en0_no_err", {63'h0, sel_err}, 64'h0);

    // Illegal select captured: out_q 0, flag sets and sticks.
    en = 1'b1;
    tick();
    chk("ill_q", out_q, 64'h0);
    chk("ill_vld", {63'h0, out_vld}, 64'h1);
    chk("ill_err_set", {63'h0, sel_err}, 64'h1);
    en = 1'b0; sel = 2'b00;
    tick(); tick();
    chk("err_sticky", {63'h0, sel_err}, 64'h1);
    sel_err_clr = 1'b1;
    tick();
    chk("err_clr", {63'h0, sel_err}, 64'h0);
    sel_err_clr = 1'b0;

    // Pipelined capture one cycle behind out.
    en = 1'b1; sel = 2'b01;
    tick();
    chk("pipe_b", out_q, VB);
    chk("pipe_b_vld", {63'h0, out_vld}, 64'h1);
    sel = 2'b10;
    tick();
    chk("pipe_c", out_q, VC);
    chk("pipe_c_vld", {63'h0, out_vld}, 64'h1);
    en = 1'b0;
    tick();
    chk("pipe_hold", out_q, VC);
    chk("pipe_hold_vld", {63'h0, out_vld}, 64'h0);

    // Asynchronous reset between edges, with flag and valid both set first.
    en = 1'b1; sel = 2'b11;
    tick();
    sel = 2'b01;
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_q", out_q, 64'h0);
    chk("arst_vld", {63'h0, out_vld}, 64'h0);
    chk("arst_err", {63'h0, sel_err}, 64'h0);
    sel = 2'b10; #1;
    chk("arst_out_follows", out, VC);
    tick();
    chk("arst_edge_q", out_q, 64'h0);
    @(negedge clk);
    rst = 1'b0; en = 1'b1; sel = 2'b00;
    tick();
    chk("post_rst_a", out_q, VA);
    chk("post_rst_vld", {63'h0, out_vld}, 64'h1);

    // Set and clear on the same edge: set wins.
    sel = 2'b11; sel_err_clr = 1'b1;
    tick();
    chk("set_beats_clr", {63'h0, sel_err}, 64'h1);
    en = 1'b0;
    tick();
    chk("clr_after", {63'h0, sel_err}, 64'h0);
    sel_err_clr = 1'b0;

`ifdef MUX3TO1_FWD_STATS_EN
    @(negedge clk); rst = 1'b1; #1; rst = 1'b0;
    chk("cnt_rst_a", {60'h0, cnt_a}, 64'd0);
    en = 1'b1; sel = 2'b00;
    for (int i = 0; i < 20; i++) tick();
    chk("cnt_sat_a", {60'h0, cnt_a}, 64'd15);
    chk("cnt_sat_b", {60'h0, cnt_b}, 64'd0);
    chk("cnt_sat_c", {60'h0, cnt_c}, 64'd0);
    sel = 2'b01; tick(); tick();
    sel = 2'b10; tick();
    sel = 2'b11; tick();
    chk("cnt_b2", {60'h0, cnt_b}, 64'd2);
    chk("cnt_c1", {60'h0, cnt_c}, 64'd1);
    en = 1'b0; sel = 2'b01; tick();
    chk("cnt_b_en0", {60'h0, cnt_b}, 64'd2);
    #2; rst = 1'b1; #1;
    chk("cnt_clr_a", {60'h0, cnt_a}, 64'd0);
    chk("cnt_clr_b", {60'h0, cnt_b}, 64'd0);
    chk("cnt_clr_c", {60'h0, cnt_c}, 64'd0);
    rst = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mux3to1_fwd.md
Name: mux3to1_fwd

Overview:
- 3-to-1 WIDTH-bit selector for the pipeline forwarding paths (ALU operand select: register-file value, EX/MEM result, MEM/WB result).
- Provides a purely combinational output plus a one-cycle registered copy with valid tracking.
- Includes a sticky flag that records use of the unused select code.

Parameters:
- WIDTH, 64, data width of A, B, C, out and out_q.
- CNT_W, 16, width of each usage counter (optional feature only).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- A  input  WIDTH  source 0.
- B  input  WIDTH  source 1.
- C  input  WIDTH  source 2.
- sel  input  2  select: 00=A, 01=B, 10=C, 11=illegal.
- en  input  1  capture enable for the registered path.
- out  output  WIDTH  combinational selected value.
- out_q  output  WIDTH  registered selected value.
- out_vld  output  1  out_q holds a value captured with en=1.
- sel_err  output  1  sticky: sel==11 was seen while en=1.
- sel_err_clr  input  1  synchronous clear of sel_err.

Behaviour:
- Combinational path, zero latency, with no dependence on clk or rst:
  - out = A when sel=00, B when sel=01, C when sel=10.
  - out = all zeros when sel=11.
  - If sel contains X or Z, out is all zeros; no X propagation.
- Registered path, updated on the rising clk edge:
  - en=1: out_q <= out (same mapping, including 0 for sel=11) and out_vld <= 1.
  - en=0: out_q holds its value and out_vld <= 0.
- Latency: out_q and out_vld reflect the inputs sampled one cycle earlier.
- sel_err:
  - Set on any edge where en=1 and sel=11.
  - Cleared on an edge where sel_err_clr=1.
  - If set and clear occur on the same edge, set wins and sel_err stays 1.
  - sel=11 with en=0 does not set the flag.
- Reset (rst=1, asynchronous, takes effect immediately): out_q=0, out_vld=0, sel_err=0.
  - out keeps following its inputs during reset.
  - Reset has priority over en and over sel_err_clr.
  - Registered state resumes capturing on the first rising edge after rst deasserts.
- No arithmetic is performed; all data paths are exactly WIDTH bits with no truncation or extension.

Optional Feature:
- Macro: MUX3TO1_FWD_STATS_EN.
- When defined:
  - Adds three outputs cnt_a, cnt_b, cnt_c, each CNT_W bits.
  - Each counter increments by 1 on an edge where en=1 and sel selects its source.
  - Counters saturate at all-ones; they do not wrap.
  - Reset sets all three counters to 0.
  - Illegal sel=11 increments no counter.
- When not defined: the counter ports and logic are absent; all other behaviour is identical.

Test Plan:
- A=AAAA_AAAA_AAAA_AAAA, B=BBBB_BBBB_BBBB_BBBB, C=CCCC_CCCC_CCCC_CCCC. Step sel 00,01,10 with a 10-unit hold each, en=0 -> out = A, B, C respectively; out_vld=0.
- Same data, sel=11 -> out = 0000_0000_0000_0000. With en=1, after the next edge: out_q=0, sel_err=1. sel_err stays 1 until sel_err_clr=1 on a later edge.
- en=1, sel=01 then sel=10 on consecutive edges -> out_q = BBBB... then CCCC... one cycle behind out; out_vld=1 both cycles. Drop en -> out_q holds CCCC..., out_vld=0.
- Assert rst mid-stream between clock edges -> out_q=0, out_vld=0, sel_err=0 immediately, while out still follows sel. Deassert rst, en=1, sel=00 -> out_q=AAAA... after the first edge.
- sel_err_clr=1 and (en=1, sel=11) on the same edge -> sel_err remains 1.
- With MUX3TO1_FWD_STATS_EN and CNT_W=4: 20 edges with en=1, sel=00 -> cnt_a=15 (saturated), cnt_b=0, cnt_c=0. Reset -> all counters 0.
